// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding controller for the 5-stage core: EX operand forwarding, load-use bubble,
// branch flush and memBusy freeze. Define HAZARD_PERF_EN to add saturating performance counters.
module hazard_forward_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int PERF_CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] decodeRs1,
  input  logic [REG_ADDR_W-1:0] decodeRs2,
  input  logic                  decodeUseRs1,
  input  logic                  decodeUseRs2,
  input  logic [REG_ADDR_W-1:0] decodeRd,
  input  logic                  decodeRegWrite,
  input  logic                  decodeMemRead,
  input  logic                  branchTaken,
  input  logic                  memBusy,
  output logic [1:0]            forwardSelect1,
  output logic [1:0]            forwardSelect2,
  output logic                  stallFetch,
  output logic                  stallDecode,
  output logic                  bubbleExecute,
  output logic                  flushDecode,
  output logic                  freezeBackend
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] loadStallCount,
  output logic [PERF_CNT_W-1:0] flushCount,
  output logic [PERF_CNT_W-1:0] memStallCount
`endif
);

  typedef enum logic [1:0] {RUN, LDSTALL, MEMWAIT} state_t;

  state_t                  state;
  logic [REG_ADDR_W-1:0]   idex_rd, idex_rs1, idex_rs2;
  logic                    idex_reg_write, idex_mem_read;
  logic [REG_ADDR_W-1:0]   exmem_rd, memwb_rd;
  logic                    exmem_reg_write, memwb_reg_write;

  logic                    load_use;
  logic                    load_stall;
  logic                    flush;

  // EX/MEM is the younger producer, so it takes precedence over MEM/WB.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] em_rd,
    input logic                  em_wr,
    input logic [REG_ADDR_W-1:0] mw_rd,
    input logic                  mw_wr
  );
    if (em_wr && (em_rd != '0) && (em_rd == rs))      return 2'b01;
    else if (mw_wr && (mw_rd != '0) && (mw_rd == rs)) return 2'b10;
    else                                              return 2'b00;
  endfunction

  assign load_use = idex_mem_read && (idex_rd != '0) &&
                    ((decodeUseRs1 && (idex_rd == decodeRs1)) ||
                     (decodeUseRs2 && (idex_rd == decodeRs2)));

  // A taken branch kills the ID instruction, so its load-use hazard is irrelevant.
  assign flush      = !memBusy && branchTaken;
  assign load_stall = !memBusy && !branchTaken && load_use && (state != LDSTALL);

  always_comb begin
    // NOTE: every output gets a default first so no path through this block infers a latch.
    forwardSelect1 = 2'b00;
    forwardSelect2 = 2'b00;
    stallFetch     = 1'b0;
    stallDecode    = 1'b0;
    bubbleExecute  = 1'b0;
    flushDecode    = 1'b0;
    freezeBackend  = 1'b0;
    if (!reset) begin
      forwardSelect1 = fwd_sel(idex_rs1, exmem_rd, exmem_reg_write, memwb_rd, memwb_reg_write);
      forwardSelect2 = fwd_sel(idex_rs2, exmem_rd, exmem_reg_write, memwb_rd, memwb_reg_write);
      stallFetch     = memBusy || load_stall;
      stallDecode    = memBusy || load_stall;
      bubbleExecute  = flush || load_stall;
      flushDecode    = flush;
      freezeBackend  = memBusy;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= RUN;
      idex_rd         <= '0;
      idex_rs1        <= '0;
      idex_rs2        <= '0;
      idex_reg_write  <= 1'b0;
      idex_mem_read   <= 1'b0;
      exmem_rd        <= '0;
      exmem_reg_write <= 1'b0;
      memwb_rd        <= '0;
      memwb_reg_write <= 1'b0;
    end else if (memBusy) begin
      // Whole pipe holds; shadows stay put until memory is ready again.
      state <= MEMWAIT;
    end else begin
      // NOTE: non-blocking assignments let each stage copy its predecessor's old value in one edge.
      memwb_rd        <= exmem_rd;
      memwb_reg_write <= exmem_reg_write;
      exmem_rd        <= idex_rd;
      exmem_reg_write <= idex_reg_write;
      if (flush || load_stall) begin
        idex_rd        <= '0;
        idex_rs1       <= '0;
        idex_rs2       <= '0;
        idex_reg_write <= 1'b0;
        idex_mem_read  <= 1'b0;
      end else begin
        idex_rd        <= decodeRd;
        idex_rs1       <= decodeRs1;
        idex_rs2       <= decodeRs2;
        idex_reg_write <= decodeRegWrite;
        idex_mem_read  <= decodeMemRead;
      end
      state <= load_stall ? LDSTALL : RUN;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      loadStallCount <= '0;
      flushCount     <= '0;
      memStallCount  <= '0;
    end else begin
      if (load_stall && (loadStallCount != '1)) loadStallCount <= loadStallCount + 1'b1;
      if (flush && (flushCount != '1))          flushCount     <= flushCount + 1'b1;
      if (memBusy && (memStallCount != '1))     memStallCount  <= memStallCount + 1'b1;
    end
  end
`else
  localparam int unused_perf_w = PERF_CNT_W;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl: the driver queues hand-computed expectations per cycle,
// a monitor pops and compares them mid-cycle on the falling edge.
module tb_hazard_forward_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] decodeRs1 = '0, decodeRs2 = '0, decodeRd = '0;
  logic       decodeUseRs1 = 1'b0, decodeUseRs2 = 1'b0;
  logic       decodeRegWrite = 1'b0, decodeMemRead = 1'b0;
  logic       branchTaken = 1'b0, memBusy = 1'b0;
  logic [1:0] forwardSelect1, forwardSelect2;
  logic       stallFetch, stallDecode, bubbleExecute, flushDecode, freezeBackend;

  hazard_forward_ctrl #(.REG_ADDR_W(5), .PERF_CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .decodeRs1(decodeRs1), .decodeRs2(decodeRs2),
    .decodeUseRs1(decodeUseRs1), .decodeUseRs2(decodeUseRs2),
    .decodeRd(decodeRd), .decodeRegWrite(decodeRegWrite), .decodeMemRead(decodeMemRead),
    .branchTaken(branchTaken), .memBusy(memBusy),
    .forwardSelect1(forwardSelect1), .forwardSelect2(forwardSelect2),
    .stallFetch(stallFetch), .stallDecode(stallDecode), .bubbleExecute(bubbleExecute),
    .flushDecode(flushDecode), .freezeBackend(freezeBackend)
  );

  always #5 clk = ~clk;

  // Expected pack: {fs1[1:0], fs2[1:0], stallFetch, stallDecode, bubbleExecute, flushDecode, freezeBackend}
  localparam logic [8:0] E0    = 9'b00_00_00000;
  localparam logic [8:0] E_LU  = 9'b00_00_11100;
  localparam logic [8:0] E_FZ  = 9'b00_00_11001;
  localparam logic [8:0] E_BR  = 9'b00_00_00110;
  localparam logic [8:0] E_F10 = 9'b10_00_00000;
  localparam logic [8:0] E_F01 = 9'b01_00_00000;
  localparam logic [8:0] E_F11 = 9'b01_01_00000;

  typedef struct {
    logic [8:0] exp;
    string      name;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [8:0] got, input logic [8:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got fs1=%b fs2=%b sf=%b sd=%b be=%b fd=%b fb=%b, want fs1=%b fs2=%b sf=%b sd=%b be=%b fd=%b fb=%b",
               nm, got[8:7], got[6:5], got[4], got[3], got[2], got[1], got[0],
               exp[8:7], exp[6:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Monitor: outputs are combinational, so every falling edge presents a result.
  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        sb_entry_t e;
        e = sb_q.pop_front();
        check(e.name, {forwardSelect1, forwardSelect2, stallFetch, stallDecode,
                       bubbleExecute, flushDecode, freezeBackend}, e.exp);
      end
    end
  end

  task automatic step(input string nm, input logic rst_v,
                      input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                      input logic [4:0] rdv, input logic rw, input logic mr,
                      input logic br, input logic mb, input logic [8:0] exp);
    sb_entry_t e;
    @(posedge clk);
    #1;
    reset          = rst_v;
    decodeRs1      = r1;
    decodeUseRs1   = u1;
    decodeRs2      = r2;
    decodeUseRs2   = u2;
    decodeRd       = rdv;
    decodeRegWrite = rw;
    decodeMemRead  = mr;
    branchTaken    = br;
    memBusy        = mb;
    e.exp  = exp;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //    name            rst rs1 u1 rs2 u2 rd  rw mr br mb expected
    step("rst_gate",      1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 1, 1, E0);
    step("rst_idle",      1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, E0);
    // lw x5 then add x6,x5,x1 then sub x7,x6,x5
    step("lw_x5",         0, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0, E0);
    step("lu_stall",      0, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0, 0, E_LU);
    step("ldstall_one",   0, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0, 0, E0);
    step("fwd_memwb_10",  0, 5'd6, 1, 5'd5, 1, 5'd7, 1, 0, 0, 0, E_F10);
    step("fwd_exmem_01",  0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, E_F01);
    // two writers of x3, then add x4,x3,x3
    step("addi_x3_a",     0, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 0, 0, E0);
    step("addi_x3_b",     0, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 0, 0, E0);
    step("add_x4",        0, 5'd3, 1, 5'd3, 1, 5'd4, 1, 0, 0, 0, E0);
    step("both_prio_01",  0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, E_F11);
    // x0 never forwards, lw x0 never stalls
    step("addi_x0",       0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 0, E0);
    step("add_x8_x0",     0, 5'd0, 1, 5'd0, 1, 5'd8, 1, 0, 0, 0, E0);
    step("x0_no_fwd",     0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, E0);
    step("lw_x0",         0, 5'd2, 1, 5'd0, 0, 5'd0, 1, 1, 0, 0, E0);
    step("x0_no_stall",   0, 5'd0, 1, 5'd0, 1, 5'd9, 1, 0, 0, 0, E0);
    // branch in the same cycle as a load-use hazard
    step("lw_x10",        0, 5'd1, 1, 5'd0, 0, 5'd10, 1, 1, 0, 0, E0);
    step("br_over_lu",    0, 5'd10, 1, 5'd10, 1, 5'd11, 1, 0, 1, 0, E_BR);
    step("after_br_run",  0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, E0);
    // memBusy for three cycles over a load-use hazard
    step("lw_x12",        0, 5'd1, 1, 5'd0, 0, 5'd12, 1, 1, 0, 0, E0);
    step("freeze_1",      0, 5'd12, 1, 5'd0, 1, 5'd13, 1, 0, 0, 1, E_FZ);
    step("freeze_2",      0, 5'd12, 1, 5'd0, 1, 5'd13, 1, 0, 0, 1, E_FZ);
    step("freeze_3",      0, 5'd12, 1, 5'd0, 1, 5'd13, 1, 0, 0, 1, E_FZ);
    step("lu_after_frz",  0, 5'd12, 1, 5'd0, 1, 5'd13, 1, 0, 0, 0, E_LU);
    step("ldstall_two",   0, 5'd12, 1, 5'd0, 1, 5'd13, 1, 0, 0, 0, E0);
    step("fwd_after_frz", 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, E_F10);
    // memBusy outranks branchTaken
    step("busy_over_br",  0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 1, E_FZ);
    step("br_after_busy", 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, E_BR);
    // reset in LDSTALL, with a load in ID/EX, and in MEMWAIT
    step("lw_x14",        0, 5'd1, 1, 5'd0, 0, 5'd14, 1, 1, 0, 0, E0);
    step("lu_x14",        0, 5'd14, 1, 5'd14, 1, 5'd15, 1, 0, 0, 0, E_LU);
    step("rst_in_ldst",   1, 5'd14, 1, 5'd14, 1, 5'd15, 1, 0, 0, 0, E0);
    step("lw_x14_again",  0, 5'd1, 1, 5'd0, 0, 5'd14, 1, 1, 0, 0, E0);
    step("rst_over_lu",   1, 5'd14, 1, 5'd14, 1, 5'd15, 1, 0, 0, 0, E0);
    step("shadows_clear", 0, 5'd14, 1, 5'd14, 1, 5'd15, 1, 0, 0, 0, E0);
    step("busy_pre_rst",  0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, E_FZ);
    step("rst_in_mwait",  1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 1, E0);
    step("run_after_rst", 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, E0);

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
